// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control blocks: forwarding selects,
// mult/div op encodings, default mult/div latencies and the register-hit helper.
package mips_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic MD_MULT = 1'b0;
  localparam logic MD_DIV  = 1'b1;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 32;
  localparam int CNT_W_DEF       = 6;

  // A write to $0 is discarded by the register file, so it never hazards or forwards.
  function automatic logic reg_hit(input logic we, input logic [4:0] dst, input logic [4:0] src);
    return we && (dst != 5'd0) && (dst == src);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic weM, input logic [4:0] dstM,
                                         input logic weW, input logic [4:0] dstW,
                                         input logic [4:0] src);
    if (reg_hit(weM, dstM, src))      return FWD_M;
    else if (reg_hit(weW, dstW, src)) return FWD_W;
    else                              return FWD_RF;
  endfunction

endpackage

// File: rtl/md_busy_timer.sv
// Busy timer for the sequential multiply/divide unit: loads the op latency when
// an op enters E and counts down until HI/LO are valid.
module md_busy_timer
  import mips_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic op,
  output logic busy
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  // A new op always reloads the full latency; back-to-back ops never accumulate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= (op == MD_DIV) ? DIV_LOAD : MULT_LOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - ONE;
    end
  end

  assign busy = (cnt != '0) || start;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS core: stalls, ID/EX flush and forwarding
// selects. Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic       useRsD,
  input  logic       useRtD,
  input  logic       branchD,
  input  logic       mdUseD,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic [4:0] writeRegE,
  input  logic       regWriteE,
  input  logic       memToRegE,
  input  logic       mdStartE,
  input  logic       mdOpE,
  input  logic [4:0] writeRegM,
  input  logic       regWriteM,
  input  logic       memToRegM,
  input  logic [4:0] writeRegW,
  input  logic       regWriteW,
  output logic       stallF,
  output logic       stallD,
  output logic       flushE,
  output logic       fwdAD,
  output logic       fwdBD,
  output logic [1:0] fwdAE,
  output logic [1:0] fwdBE,
  output logic       mdBusy
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] perfStallCnt,
  output logic [31:0] perfMdStallCnt
`endif
);

  logic md_busy_raw;
  logic lw_stall;
  logic br_stall;
  logic md_stall;
  logic stall;

  md_busy_timer #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_md_busy_timer (
    .clk  (clk),
    .rst  (rst),
    .start(mdStartE),
    .op   (mdOpE),
    .busy (md_busy_raw)
  );

  always_comb begin
    lw_stall = (useRsD && reg_hit(memToRegE && regWriteE, writeRegE, rsD)) ||
               (useRtD && reg_hit(memToRegE && regWriteE, writeRegE, rtD));
    // A branch compares in D, so any pending E write or an M load is not yet forwardable.
    br_stall = branchD && (reg_hit(regWriteE, writeRegE, rsD) ||
                           reg_hit(regWriteE, writeRegE, rtD) ||
                           reg_hit(memToRegM, writeRegM, rsD) ||
                           reg_hit(memToRegM, writeRegM, rtD));
    md_stall = mdUseD && md_busy_raw;
    stall    = lw_stall || br_stall || md_stall;
  end

  // Every output is forced inactive while reset is held.
  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    flushE = 1'b0;
    fwdAD  = 1'b0;
    fwdBD  = 1'b0;
    fwdAE  = FWD_RF;
    fwdBE  = FWD_RF;
    mdBusy = 1'b0;
    if (!rst) begin
      stallF = stall;
      stallD = stall;
      flushE = stall;
      fwdAD  = reg_hit(regWriteM, writeRegM, rsD);
      fwdBD  = reg_hit(regWriteM, writeRegM, rtD);
      fwdAE  = fwd_sel(regWriteM, writeRegM, regWriteW, writeRegW, rsE);
      fwdBE  = fwd_sel(regWriteM, writeRegM, regWriteW, writeRegW, rtE);
      mdBusy = md_busy_raw;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perfStallCnt   <= '0;
      perfMdStallCnt <= '0;
    end else begin
      if (stall && (perfStallCnt != 32'hFFFF_FFFF)) begin
        perfStallCnt <= perfStallCnt + 32'd1;
      end
      if (md_stall && (perfMdStallCnt != 32'hFFFF_FFFF)) begin
        perfMdStallCnt <= perfMdStallCnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl: load-use, branch, forwarding priority,
// $0 immunity, mult/div busy timing and reset abort.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW;
  logic       useRsD, useRtD, branchD, mdUseD;
  logic       regWriteE, memToRegE, mdStartE, mdOpE;
  logic       regWriteM, memToRegM, regWriteW;
  logic       stallF, stallD, flushE, fwdAD, fwdBD, mdBusy;
  logic [1:0] fwdAE, fwdBE;

  int total = 0;
  int bad   = 0;
  int n_stall;
  int first_idle;

  hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .rsD(rsD), .rtD(rtD), .useRsD(useRsD), .useRtD(useRtD),
    .branchD(branchD), .mdUseD(mdUseD),
    .rsE(rsE), .rtE(rtE), .writeRegE(writeRegE), .regWriteE(regWriteE),
    .memToRegE(memToRegE), .mdStartE(mdStartE), .mdOpE(mdOpE),
    .writeRegM(writeRegM), .regWriteM(regWriteM), .memToRegM(memToRegM),
    .writeRegW(writeRegW), .regWriteW(regWriteW),
    .stallF(stallF), .stallD(stallD), .flushE(flushE),
    .fwdAD(fwdAD), .fwdBD(fwdBD), .fwdAE(fwdAE), .fwdBE(fwdBE),
    .mdBusy(mdBusy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    rsD = 0; rtD = 0; useRsD = 0; useRtD = 0; branchD = 0; mdUseD = 0;
    rsE = 0; rtE = 0; writeRegE = 0; regWriteE = 0; memToRegE = 0;
    mdStartE = 0; mdOpE = 0; writeRegM = 0; regWriteM = 0; memToRegM = 0;
    writeRegW = 0; regWriteW = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packed as {stallF,stallD,flushE,fwdAD,fwdBD,fwdAE,fwdBE,mdBusy}.
  task automatic chk_all(input string tag, input logic s, input logic ad, input logic bd,
                         input logic [1:0] ae, input logic [1:0] be, input logic busy);
    chk(tag, 32'({stallF, stallD, flushE, fwdAD, fwdBD, fwdAE, fwdBE, mdBusy}),
             32'({s, s, s, ad, bd, ae, be, busy}));
  endtask

  initial begin
    // Reset held with inputs that would otherwise assert everything
    idle();
    rst = 1'b1;
    regWriteM = 1; writeRegM = 5; rsE = 5; rtE = 5; rsD = 5; rtD = 5;
    mdUseD = 1; mdStartE = 1; branchD = 1; regWriteE = 1; writeRegE = 5;
    #1;
    chk_all("reset_outputs", 0, 0, 0, 2'b00, 2'b00, 0);
    tick(); tick();
    chk_all("reset_held_after_clk", 0, 0, 0, 2'b00, 2'b00, 0);
    idle();
    rst = 1'b0;
    #1;
    chk_all("after_reset_idle", 0, 0, 0, 2'b00, 2'b00, 0);

    // Load-use on rs
    tick(); idle();
    memToRegE = 1; regWriteE = 1; writeRegE = 2; useRsD = 1; rsD = 2; useRtD = 1; rtD = 7;
    #1; chk_all("loaduse_rs", 1, 0, 0, 2'b00, 2'b00, 0);
    rsD = 9; rtD = 2;
    #1; chk_all("loaduse_rt", 1, 0, 0, 2'b00, 2'b00, 0);
    rsD = 2; rtD = 7; useRsD = 0;
    #1; chk_all("loaduse_unused_rs", 0, 0, 0, 2'b00, 2'b00, 0);
    // Load now in M, consumer in E
    tick(); idle();
    regWriteM = 1; memToRegM = 1; writeRegM = 2; rsE = 2;
    #1; chk_all("loaduse_fwd_next", 0, 0, 0, 2'b10, 2'b00, 0);

    // $0 immunity
    tick(); idle();
    regWriteM = 1; writeRegM = 0; rsE = 0; rtE = 0; rsD = 0;
    #1; chk_all("zero_no_fwd", 0, 0, 0, 2'b00, 2'b00, 0);
    idle();
    memToRegE = 1; regWriteE = 1; writeRegE = 0; useRsD = 1; rsD = 0;
    #1; chk_all("zero_no_loaduse", 0, 0, 0, 2'b00, 2'b00, 0);

    // M over W priority
    tick(); idle();
    regWriteM = 1; writeRegM = 5; regWriteW = 1; writeRegW = 5; rsE = 5; rtE = 5;
    #1; chk_all("prio_m_over_w", 0, 0, 0, 2'b10, 2'b10, 0);
    regWriteM = 0;
    #1; chk_all("prio_w_only", 0, 0, 0, 2'b01, 2'b01, 0);
    rsE = 1;
    #1; chk_all("prio_rt_only", 0, 0, 0, 2'b00, 2'b01, 0);

    // Branch dependency
    tick(); idle();
    branchD = 1; rsD = 3; rtD = 4; regWriteE = 1; writeRegE = 3;
    #1; chk_all("branch_e_stall", 1, 0, 0, 2'b00, 2'b00, 0);
    tick(); idle();
    branchD = 1; rsD = 3; rtD = 4; regWriteM = 1; writeRegM = 3;
    #1; chk_all("branch_m_fwd", 0, 1, 0, 2'b00, 2'b00, 0);
    rtD = 3;
    #1; chk_all("branch_m_fwd_both", 0, 1, 1, 2'b00, 2'b00, 0);
    rtD = 4; memToRegM = 1;
    #1; chk_all("branch_m_load_stall", 1, 1, 0, 2'b00, 2'b00, 0);

    // Mult: stall t..t+5, release at t+6
    tick(); idle();
    mdStartE = 1; mdOpE = 0; mdUseD = 1;
    #1; chk_all("mult_t0", 1, 0, 0, 2'b00, 2'b00, 1);
    for (int k = 1; k <= 5; k++) begin
      tick(); idle(); mdUseD = 1;
      #1; chk_all($sformatf("mult_t%0d", k), 1, 0, 0, 2'b00, 2'b00, 1);
    end
    tick(); idle(); mdUseD = 1;
    #1; chk_all("mult_t6_release", 0, 0, 0, 2'b00, 2'b00, 0);

    // Restart reloads instead of stacking: starts at t and t+2, idle again at t+8
    tick(); idle(); mdStartE = 1;
    tick(); idle();
    tick(); idle(); mdStartE = 1;
    for (int k = 3; k <= 7; k++) begin
      tick(); idle();
    end
    #1; chk_all("restart_t7_busy", 0, 0, 0, 2'b00, 2'b00, 1);
    tick(); idle();
    #1; chk_all("restart_t8_idle", 0, 0, 0, 2'b00, 2'b00, 0);

    // Div: 33 stall cycles, busy clears at t+33
    tick(); idle();
    mdStartE = 1; mdOpE = 1; mdUseD = 1;
    n_stall = 0; first_idle = -1;
    #1;
    if (stallF) n_stall++;
    for (int k = 1; k < 40; k++) begin
      tick(); idle(); mdUseD = 1;
      if (k == 10) begin
        memToRegE = 1; regWriteE = 1; writeRegE = 6; useRsD = 1; rsD = 6;
      end
      #1;
      if (k == 10) chk_all("div_plus_loaduse_single", 1, 0, 0, 2'b00, 2'b00, 1);
      if (k == 11) begin
        mdUseD = 0;
        #1; chk_all("div_busy_no_consumer", 0, 0, 0, 2'b00, 2'b00, 1);
        mdUseD = 1;
        #1;
      end
      if (stallF) n_stall++;
      if (!mdBusy && first_idle < 0) first_idle = k;
    end
    chk("div_stall_cycles", 32'(n_stall), 32'd33);
    chk("div_busy_clear_cycle", 32'(first_idle), 32'd33);

    // Reset mid-div when the count reaches 20 (t+13)
    tick(); idle();
    mdStartE = 1; mdOpE = 1;
    for (int k = 1; k <= 13; k++) begin
      tick(); idle();
    end
    mdUseD = 1; regWriteM = 1; writeRegM = 8; rsE = 8;
    #1; chk_all("middiv_before_rst", 1, 0, 0, 2'b10, 2'b00, 1);
    rst = 1'b1;
    #1; chk_all("middiv_rst_outputs", 0, 0, 0, 2'b00, 2'b00, 0);
    tick();
    rst = 1'b0; idle(); mdUseD = 1;
    #1; chk_all("after_abort_mfhi", 0, 0, 0, 2'b00, 2'b00, 0);
    tick(); idle(); mdUseD = 1;
    #1; chk_all("after_abort_next", 0, 0, 0, 2'b00, 2'b00, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
